// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer. It drives one external one-bit full adder,
// LSB first, and holds the ripple carry in a register between bits.
// Each operation takes WIDTH RUN cycles followed by a one-cycle DONE pulse.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] res_sh_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    // Next value of the result shift register: the new sum bit enters at the MSB.
    // A one-bit adder has no older bits to shift down, so it takes fa_sum directly.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_sh_d = fa_sum;
        end else begin : g_res_wn
            assign res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer: captures operands, steps one bit per clock, and publishes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_sh_q <= res_sh_d;
                    c_q      <= fa_cout;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= res_sh_d;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Adder operands are driven only while running and are held at zero otherwise.
    always_comb begin
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state_q == S_RUN) begin
            fa_a   = a_sh_q[0];
            fa_b   = b_sh_q[0];
            fa_cin = c_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1,
// with a behavioural one-bit full adder on the fa_* port.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;

    // WIDTH=8 instance
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    // WIDTH=1 instance
    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;
    logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;

    int unsigned n_checks;
    int unsigned n_fail;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
        .fa_sum(fa_sum1), .fa_cout(fa_cout1)
    );

    // One-bit full adders
    assign {fa_cout, fa_sum}   = 2'(fa_a)  + 2'(fa_b)  + 2'(fa_cin);
    assign {fa_cout1, fa_sum1} = 2'(fa_a1) + 2'(fa_b1) + 2'(fa_cin1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one op on the WIDTH=8 instance, starting from an IDLE negedge.
    // lat counts negedges after the start edge up to the one where done is seen (0 = timeout).
    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                         output int unsigned lat, output logic [7:0] s, output logic c,
                         output logic done_after, output logic busy_after,
                         output int unsigned busy_bad);
        lat = 0; s = '0; c = 1'b0; busy_bad = 0;
        a = ai; b = bi; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ai; b = ~bi; cin = ~ci;
        for (int unsigned i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = i;
                s = sum;
                c = cout;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #23;
        n_checks++;
        if ({busy, done, sum, cout} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
        end
        n_checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_fa: got %b%b%b, expected 000", fa_a, fa_b, fa_cin);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b, expected all 0", busy1, done1, sum1, cout1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int unsigned lat, bb;
        logic [7:0] s;
        logic c, da, ba;
        do_op(8'h5A, 8'h33, 1'b0, lat, s, c, da, ba, bb);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, expected 9", lat);
        end
        n_checks++;
        if ({c, s} !== 9'h08D) begin
            n_fail++;
            $display("FAIL basic_sum: got cout=%b sum=%h, expected cout=0 sum=8d", c, s);
        end
        n_checks++;
        if ({da, ba} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_after_done: got done=%b busy=%b, expected 0 0", da, ba);
        end
        n_checks++;
        if (bb !== 0) begin
            n_fail++;
            $display("FAIL basic_busy: got %0d cycles with busy low, expected 0", bb);
        end
        n_checks++;
        if (sum !== 8'h8D) begin
            n_fail++;
            $display("FAIL basic_hold: got sum=%h in IDLE, expected 8d", sum);
        end
    endtask

    task automatic test_carry;
        int unsigned lat, bb;
        logic [7:0] s;
        logic c, da, ba;
        do_op(8'hFF, 8'h01, 1'b0, lat, s, c, da, ba, bb);
        n_checks++;
        if ({c, s} !== 9'h100) begin
            n_fail++;
            $display("FAIL carry_ff_01: got cout=%b sum=%h, expected cout=1 sum=00", c, s);
        end
        do_op(8'hFF, 8'hFF, 1'b1, lat, s, c, da, ba, bb);
        n_checks++;
        if ({c, s} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL carry_ff_ff_1: got cout=%b sum=%h, expected cout=1 sum=ff", c, s);
        end
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL carry_latency: got %0d, expected 9", lat);
        end
    endtask

    // start held high the whole time; first op captures 01+02, later values must not leak in
    task automatic test_back_to_back;
        int unsigned dones, done_at, lat2;
        logic [7:0] s2;
        dones = 0; done_at = 0; lat2 = 0; s2 = '0;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int unsigned i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                done_at = i;
            end
            a = 8'(8'hC0 + i); b = 8'(8'h30 + 2 * i); cin = 1'b1;
        end
        n_checks++;
        if (dones !== 1 || done_at !== 9) begin
            n_fail++;
            $display("FAIL b2b_single_done: got %0d pulses (last at %0d), expected 1 at 9", dones, done_at);
        end
        n_checks++;
        if ({cout, sum} !== 9'h003) begin
            n_fail++;
            $display("FAIL b2b_first_capture: got cout=%b sum=%h, expected cout=0 sum=03", cout, sum);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b at cycle 10, expected 0", busy);
        end
        a = 8'h10; b = 8'h05; cin = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b after first IDLE cycle, expected 1", busy);
        end
        start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int unsigned i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat2 = i;
                s2 = sum;
                break;
            end
        end
        n_checks++;
        if (lat2 !== 9 || s2 !== 8'h15 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_op: got lat=%0d sum=%h cout=%b, expected lat=9 sum=15 cout=0", lat2, s2, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int unsigned dones, lat, bb;
        logic [7:0] s;
        logic c, da, ba;
        dones = 0;
        a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, sum, cout} !== 11'h000) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
        end
        n_checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_fa: got %b%b%b, expected 000", fa_a, fa_b, fa_cin);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d cycles with done/busy high, expected 0", dones);
        end
        do_op(8'h10, 8'h20, 1'b0, lat, s, c, da, ba, bb);
        n_checks++;
        if ({c, s} !== 9'h030 || lat !== 9) begin
            n_fail++;
            $display("FAIL midrun_recover: got cout=%b sum=%h lat=%0d, expected cout=0 sum=30 lat=9", c, s, lat);
        end
    endtask

    task automatic test_width1;
        logic [2:0] vec [3];
        logic [1:0] exp_res [3];
        int unsigned lat;
        vec[0] = 3'b111; exp_res[0] = 2'b11;
        vec[1] = 3'b010; exp_res[1] = 2'b01;
        vec[2] = 3'b101; exp_res[2] = 2'b10;
        for (int unsigned k = 0; k < 3; k++) begin
            lat = 0;
            a1 = vec[k][2]; b1 = vec[k][1]; cin1 = vec[k][0]; start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            for (int unsigned i = 1; i <= 6; i++) begin
                @(negedge clk);
                if (done1 === 1'b1) begin
                    lat = i;
                    break;
                end
            end
            n_checks++;
            if (lat !== 2 || {cout1, sum1} !== exp_res[k]) begin
                n_fail++;
                $display("FAIL w1_op%0d: got lat=%0d cout=%b sum=%b, expected lat=2 result=%b", k, lat, cout1, sum1, exp_res[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        int unsigned lat, bb, gap;
        logic [7:0] s, ra, rb;
        logic c, rc, da, ba;
        logic [8:0] exp_v;
        for (int unsigned k = 0; k < 300; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            gap = $urandom_range(0, 3);
            for (int unsigned g = 0; g < gap; g++) begin
                @(negedge clk);
                if (busy !== 1'b0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_idle_busy: got busy=%b in IDLE gap, expected 0", busy);
                end
            end
            exp_v = 9'(ra) + 9'(rb) + 9'(rc);
            do_op(ra, rb, rc, lat, s, c, da, ba, bb);
            n_checks++;
            if ({c, s} !== exp_v || lat !== 9) begin
                n_fail++;
                $display("FAIL rand_op%0d: %h+%h+%b got %h lat=%0d, expected %h lat=9", k, ra, rb, rc, {c, s}, lat, exp_v);
            end
            n_checks++;
            if (da !== 1'b0 || ba !== 1'b0 || bb !== 0) begin
                n_fail++;
                $display("FAIL rand_handshake%0d: got done_after=%b busy_after=%b busy_gaps=%0d, expected 0 0 0", k, da, ba, bb);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
